// File: rtl/fp_link_pkg.sv
// Shared definitions for the fingerprint UART link: sync byte, frame size,
// byte-serialiser state encoding and the checksum used by both link ends.
package fp_link_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_BYTES   = 6;

  localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
  localparam logic [1:0] ST_START_ENC = 2'b01;
  localparam logic [1:0] ST_DATA_ENC  = 2'b10;
  localparam logic [1:0] ST_STOP_ENC  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_START = ST_START_ENC,
    ST_DATA  = ST_DATA_ENC,
    ST_STOP  = ST_STOP_ENC
  } tx_state_e;

  // XOR of the four bytes of a result word; the receiver recomputes the same.
  function automatic logic [7:0] fp_chk(input logic [31:0] word);
    fp_chk = word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first. A byte offered while the stop bit ends is
// taken immediately, so consecutive bytes leave no idle gap on the line.
module uart_tx_byte
  import fp_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_tx_line
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [CNT_W-1:0] w_baud_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_line;
  logic             w_line_nxt;
  logic             w_bit_end;

  assign w_bit_end  = (r_baud_cnt == CNT_LAST);
  assign o_tx_ready = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end);
  assign o_tx_line  = r_line;

  // Next-state and datapath decode for the bit sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_line_nxt     = r_line;
    case (r_state)
      ST_IDLE: begin
        w_baud_cnt_nxt = CNT_ZERO;
        w_bit_idx_nxt  = 3'd0;
        if (i_tx_valid) begin
          w_state_nxt = ST_START;
          w_shift_nxt = i_tx_data;
          w_line_nxt  = 1'b0;
        end else begin
          w_line_nxt  = 1'b1;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt    = ST_DATA;
          w_baud_cnt_nxt = CNT_ZERO;
          w_bit_idx_nxt  = 3'd0;
          w_line_nxt     = r_shift[0];
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = CNT_ZERO;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_line_nxt  = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_line_nxt    = r_shift[1];
          end
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = CNT_ZERO;
          w_bit_idx_nxt  = 3'd0;
          if (i_tx_valid) begin
            w_state_nxt = ST_START;
            w_shift_nxt = i_tx_data;
            w_line_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_line_nxt  = 1'b1;
          end
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_baud_cnt_nxt = CNT_ZERO;
        w_bit_idx_nxt  = 3'd0;
        w_line_nxt     = 1'b1;
      end
    endcase
  end

  // Sequencer registers; reset parks the line high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= CNT_ZERO;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_line     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_line     <= w_line_nxt;
    end
  end

endmodule

// File: rtl/fingerprint_result_tx.sv
// Frames a 32-bit result word as SYNC, 4 data bytes MSB-first and an XOR
// checksum, and streams it out through the byte serialiser.
module fingerprint_result_tx
  import fp_link_pkg::*;
#(
  parameter int         CLK_FREQ     = 12_000_000,
  parameter int         BAUD_RATE    = 57_600,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_data_in,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_dropped,
  output logic        o_uart_tx
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  // The sync byte goes out straight from the parameter, so only the
  // payload (data bytes and checksum) needs buffering.
  logic [39:0] r_payload;
  logic [2:0]  r_byte_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_dropped;
  logic        r_start_d;

  logic        w_accept;
  logic        w_byte_end;
  logic        w_frame_last;
  logic        w_start_rise;
  logic        w_tx_valid;
  logic [7:0]  w_tx_data;
  logic [7:0]  w_next_byte;
  logic        w_tx_ready;
  logic        w_tx_line;

  assign w_accept     = ~r_busy & i_start;
  assign w_byte_end   = r_busy & w_tx_ready;
  assign w_frame_last = w_byte_end & (r_byte_idx == LAST_IDX);
  // Only a fresh request is reported as dropped; a held start just waits.
  assign w_start_rise = i_start & ~r_start_d;

  // Byte following the one currently on the line.
  always_comb begin
    w_next_byte = 8'h00;
    case (r_byte_idx)
      3'd0:    w_next_byte = r_payload[39:32];
      3'd1:    w_next_byte = r_payload[31:24];
      3'd2:    w_next_byte = r_payload[23:16];
      3'd3:    w_next_byte = r_payload[15:8];
      3'd4:    w_next_byte = r_payload[7:0];
      default: w_next_byte = 8'h00;
    endcase
  end

  // Offer the sync byte on a new request, else the next buffered byte.
  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_data  = SYNC_BYTE;
    if (r_busy) begin
      w_tx_valid = (r_byte_idx != LAST_IDX);
      w_tx_data  = w_next_byte;
    end else begin
      w_tx_valid = i_start;
      w_tx_data  = SYNC_BYTE;
    end
  end

  // Frame control: acceptance, byte index, status pulses.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_payload  <= 40'h00_0000_0000;
      r_byte_idx <= 3'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dropped  <= 1'b0;
      r_start_d  <= 1'b0;
    end else begin
      r_start_d <= i_start;
      r_done    <= w_frame_last;
      r_dropped <= r_busy & w_start_rise & ~w_frame_last;
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_byte_idx <= 3'd0;
        r_payload  <= {i_data_in, fp_chk(i_data_in)};
      end else if (w_frame_last) begin
        r_busy     <= 1'b0;
        r_byte_idx <= 3'd0;
      end else if (w_byte_end) begin
        r_byte_idx <= r_byte_idx + 3'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tx_valid (w_tx_valid),
    .i_tx_data  (w_tx_data),
    .o_tx_ready (w_tx_ready),
    .o_tx_line  (w_tx_line)
  );

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_dropped = r_dropped;
  assign o_uart_tx = w_tx_line;

endmodule

// File: tb/tb_fingerprint_result_tx.sv
// Directed bench for fingerprint_result_tx: default-rate instance plus a
// 115200-baud instance, each frame compared cycle by cycle to the line format.
module tb_fingerprint_result_tx;

  localparam int CPB   = 208;
  localparam int CPB_F = 104;

  typedef struct {
    int          line_err;
    logic [47:0] got;
    int          done_early;
    int          busy_err;
    int          drop_cnt;
    int          drop_at;
    logic        end_done;
    logic        end_busy;
    logic        end_line;
    logic        end_dropped;
  } frame_obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_start, f_start;
  logic [31:0] m_data, f_data;
  logic        m_busy, m_done, m_dropped, m_tx;
  logic        f_busy, f_done, f_dropped, f_tx;
  logic        sel_fast;
  logic        cur_line, cur_busy, cur_done, cur_dropped;
  int          total_cnt = 0;
  int          bad_cnt   = 0;

  always #5 clk = ~clk;

  assign cur_line    = sel_fast ? f_tx      : m_tx;
  assign cur_busy    = sel_fast ? f_busy    : m_busy;
  assign cur_done    = sel_fast ? f_done    : m_done;
  assign cur_dropped = sel_fast ? f_dropped : m_dropped;

  fingerprint_result_tx dut (
    .clk(clk), .rst_n(rst_n), .i_start(m_start), .i_data_in(m_data),
    .o_busy(m_busy), .o_done(m_done), .o_dropped(m_dropped), .o_uart_tx(m_tx)
  );

  fingerprint_result_tx #(.BAUD_RATE(115_200)) dut_fast (
    .clk(clk), .rst_n(rst_n), .i_start(f_start), .i_data_in(f_data),
    .o_busy(f_busy), .o_done(f_done), .o_dropped(f_dropped), .o_uart_tx(f_tx)
  );

  // Starts a frame, then records line/status over its whole length and the done cycle.
  task automatic drive_frame(input logic [31:0] d, input bit fast, input bit hold,
                             input int inject_at, input int cpb, input logic [47:0] exp,
                             output frame_obs_t o);
    int  b, k, pos;
    logic e;
    sel_fast = fast;
    if (fast) begin f_data = d; f_start = 1'b1; end
    else begin m_data = d; m_start = 1'b1; end
    @(negedge clk);
    if (fast) f_data = ~d; else m_data = ~d;
    if (!hold) begin
      if (fast) f_start = 1'b0; else m_start = 1'b0;
    end
    o.line_err = 0; o.got = 48'h0; o.done_early = 0; o.busy_err = 0;
    o.drop_cnt = 0; o.drop_at = -1;
    for (int n = 0; n < 60 * cpb; n++) begin
      if (n > 0) @(negedge clk);
      if (n == inject_at) m_start = 1'b1;
      if (inject_at >= 0 && n == inject_at + 1) m_start = 1'b0;
      b = n / cpb; k = b / 10; pos = b % 10;
      if (pos == 0) e = 1'b0;
      else if (pos == 9) e = 1'b1;
      else e = exp[40 - 8 * k + pos - 1];
      if (cur_line !== e) o.line_err++;
      if (pos >= 1 && pos <= 8 && (n % cpb) == cpb / 2) o.got[40 - 8 * k + pos - 1] = cur_line;
      if (cur_done !== 1'b0) o.done_early++;
      if (cur_busy !== 1'b1) o.busy_err++;
      if (cur_dropped === 1'b1) begin o.drop_cnt++; o.drop_at = n; end
    end
    @(negedge clk);
    o.end_done = cur_done; o.end_busy = cur_busy;
    o.end_line = cur_line; o.end_dropped = cur_dropped;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; m_start = 1'b0; f_start = 1'b0;
    m_data = 32'h0; f_data = 32'h0; sel_fast = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (m_tx !== 1'b1) begin bad_cnt++; $display("FAIL reset_line: got %b want 1", m_tx); end
    total_cnt++; if (m_busy !== 1'b0) begin bad_cnt++; $display("FAIL reset_busy: got %b want 0", m_busy); end
    total_cnt++; if ({m_done, m_dropped} !== 2'b00) begin bad_cnt++; $display("FAIL reset_pulses: got %b want 00", {m_done, m_dropped}); end
    total_cnt++; if (f_tx !== 1'b1) begin bad_cnt++; $display("FAIL reset_line_fast: got %b want 1", f_tx); end
    m_start = 1'b1; m_data = 32'h1111_1111;
    repeat (2) @(negedge clk);
    total_cnt++; if ({m_busy, m_tx} !== 2'b01) begin bad_cnt++; $display("FAIL start_in_reset: busy/line got %b want 01", {m_busy, m_tx}); end
    m_start = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if ({m_busy, m_tx, m_done} !== 3'b010) begin bad_cnt++; $display("FAIL post_reset_idle: busy/line/done got %b want 010", {m_busy, m_tx, m_done}); end
  endtask

  task automatic test_basic_frame();
    frame_obs_t o;
    drive_frame(32'h0019_8000, 1'b0, 1'b0, -1, CPB, 48'hA5_00_19_80_00_99, o);
    total_cnt++; if (o.line_err !== 0) begin bad_cnt++; $display("FAIL basic_line: %0d bad cycles want 0", o.line_err); end
    total_cnt++; if (o.got !== 48'hA5_00_19_80_00_99) begin bad_cnt++; $display("FAIL basic_bytes: got %h want a500198000 99", o.got); end
    total_cnt++; if (o.done_early !== 0 || o.busy_err !== 0) begin bad_cnt++; $display("FAIL basic_inflight: early done %0d busy errs %0d want 0 0", o.done_early, o.busy_err); end
    total_cnt++; if ({o.end_done, o.end_busy, o.end_line} !== 3'b101) begin bad_cnt++; $display("FAIL basic_done: done/busy/line at E0+12480 got %b want 101", {o.end_done, o.end_busy, o.end_line}); end
    @(negedge clk);
    total_cnt++; if (m_done !== 1'b0) begin bad_cnt++; $display("FAIL basic_done_width: got %b want 0", m_done); end
  endtask

  task automatic test_dropped();
    frame_obs_t o;
    repeat (4) @(negedge clk);
    drive_frame(32'h1234_5678, 1'b0, 1'b0, 5000, CPB, 48'hA5_12_34_56_78_08, o);
    total_cnt++; if (o.drop_cnt !== 1) begin bad_cnt++; $display("FAIL drop_count: got %0d want 1", o.drop_cnt); end
    total_cnt++; if (o.drop_at !== 5001) begin bad_cnt++; $display("FAIL drop_cycle: got %0d want 5001", o.drop_at); end
    total_cnt++; if (o.line_err !== 0 || o.got !== 48'hA5_12_34_56_78_08) begin bad_cnt++; $display("FAIL drop_frame: bytes %h bad cycles %0d want a512345678 08 / 0", o.got, o.line_err); end
    total_cnt++; if ({o.end_done, o.end_dropped} !== 2'b10) begin bad_cnt++; $display("FAIL drop_done: done/dropped got %b want 10", {o.end_done, o.end_dropped}); end
  endtask

  task automatic test_reset_mid_frame();
    frame_obs_t o;
    int done_seen;
    repeat (4) @(negedge clk);
    sel_fast = 1'b0; m_data = 32'h0F0F_0F0F; m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    repeat (35 * CPB + 100) @(negedge clk);
    total_cnt++; if ({m_busy, m_tx} !== 2'b10) begin bad_cnt++; $display("FAIL midframe_pre: busy/line got %b want 10", {m_busy, m_tx}); end
    rst_n = 1'b1;
    #1;
    total_cnt++; if (m_tx !== 1'b1) begin bad_cnt++; $display("FAIL async_reset_line: got %b want 1", m_tx); end
    total_cnt++; if ({m_busy, m_done, m_dropped} !== 3'b000) begin bad_cnt++; $display("FAIL async_reset_flags: got %b want 000", {m_busy, m_done, m_dropped}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_done === 1'b1 || m_tx !== 1'b1) done_seen++;
    end
    total_cnt++; if (done_seen !== 0) begin bad_cnt++; $display("FAIL abort_quiet: %0d cycles with done or low line want 0", done_seen); end
    drive_frame(32'hDEAD_BEEF, 1'b0, 1'b0, -1, CPB, 48'hA5_DE_AD_BE_EF_22, o);
    total_cnt++; if (o.line_err !== 0 || o.got !== 48'hA5_DE_AD_BE_EF_22) begin bad_cnt++; $display("FAIL after_reset_frame: bytes %h bad cycles %0d want a5deadbeef 22 / 0", o.got, o.line_err); end
    total_cnt++; if ({o.end_done, o.end_busy} !== 2'b10) begin bad_cnt++; $display("FAIL after_reset_done: got %b want 10", {o.end_done, o.end_busy}); end
  endtask

  task automatic test_back_to_back();
    frame_obs_t o1, o2;
    repeat (4) @(negedge clk);
    drive_frame(32'hFFFF_FFFF, 1'b0, 1'b1, -1, CPB, 48'hA5_FF_FF_FF_FF_00, o1);
    total_cnt++; if ({o1.end_done, o1.end_busy, o1.end_line} !== 3'b101) begin bad_cnt++; $display("FAIL b2b_gap1: done/busy/line got %b want 101", {o1.end_done, o1.end_busy, o1.end_line}); end
    drive_frame(32'h0019_8000, 1'b0, 1'b1, -1, CPB, 48'hA5_00_19_80_00_99, o2);
    m_start = 1'b0;
    total_cnt++; if (o1.line_err !== 0 || o1.got !== 48'hA5_FF_FF_FF_FF_00) begin bad_cnt++; $display("FAIL b2b_frame1: bytes %h bad cycles %0d want a5ffffffff 00 / 0", o1.got, o1.line_err); end
    total_cnt++; if (o2.line_err !== 0 || o2.got !== 48'hA5_00_19_80_00_99) begin bad_cnt++; $display("FAIL b2b_frame2: bytes %h bad cycles %0d want a500198000 99 / 0", o2.got, o2.line_err); end
    total_cnt++; if (o1.drop_cnt + o2.drop_cnt + int'(o1.end_dropped) + int'(o2.end_dropped) !== 0) begin bad_cnt++; $display("FAIL b2b_dropped: got %0d pulses want 0", o1.drop_cnt + o2.drop_cnt); end
    total_cnt++; if ({o2.end_done, o2.end_busy} !== 2'b10) begin bad_cnt++; $display("FAIL b2b_done2: got %b want 10", {o2.end_done, o2.end_busy}); end
    @(negedge clk);
    total_cnt++; if ({m_busy, m_tx} !== 2'b01) begin bad_cnt++; $display("FAIL b2b_stop: busy/line got %b want 01", {m_busy, m_tx}); end
  endtask

  task automatic test_fast_baud();
    frame_obs_t o;
    repeat (4) @(negedge clk);
    drive_frame(32'hA1B2_C3D4, 1'b1, 1'b0, -1, CPB_F, 48'hA5_A1_B2_C3_D4_04, o);
    total_cnt++; if (o.line_err !== 0) begin bad_cnt++; $display("FAIL fast_line: %0d bad cycles want 0", o.line_err); end
    total_cnt++; if (o.got !== 48'hA5_A1_B2_C3_D4_04) begin bad_cnt++; $display("FAIL fast_bytes: got %h want a5a1b2c3d4 04", o.got); end
    total_cnt++; if ({o.end_done, o.end_busy, o.done_early} !== {1'b1, 1'b0, 32'sd0}) begin bad_cnt++; $display("FAIL fast_done: done %b busy %b early %0d want 1 0 0", o.end_done, o.end_busy, o.done_early); end
    sel_fast = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_dropped();
    test_reset_mid_frame();
    test_back_to_back();
    test_fast_baud();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/fingerprint_result_tx.md
Name: fingerprint_result_tx

Overview:
- UART transmit side of the fingerprint link. Accepts a 32-bit result word, for example the 16.16 fixed-point mean from the fingerprint averaging path.
- Serialises the word as a 6-byte framed packet: sync byte, 4 data bytes MSB-first, XOR checksum. Each byte is 8N1, LSB-first.
- Sits between the result producer and the FPGA TX pin, in the same clock domain as the producer.

Parameters:
- CLK_FREQ, 12_000_000, clk frequency in Hz.
- BAUD_RATE, 57_600, line rate in bit/s.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (208 at defaults), derived by integer division. Overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-high (logic 1 = reset).
- start  in  1  request strobe; sampled on each rising clk edge.
- data_in  in  32  result word; captured on the edge that accepts start.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the final stop bit completes.
- dropped  out  1  one-cycle pulse when start is rejected because busy=1.
- uart_tx  out  1  serial line, registered, idle high.

Behaviour:
- Reset values (asserted asynchronously): uart_tx=1, busy=0, done=0, dropped=0, FSM=IDLE, byte index=0, bit counters=0, frame buffer=0.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- Acceptance: in IDLE with start=1 at edge E0:
  - frame buffer loads {SYNC_BYTE, data_in[31:24], data_in[23:16], data_in[15:8], data_in[7:0], CHK}, where CHK = XOR of the 4 data bytes.
  - After E0: busy=1, uart_tx=0, state=START_BIT.
- START_BIT: holds uart_tx=0 for exactly CLKS_PER_BIT cycles, then goes to DATA_BITS.
- DATA_BITS: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit counter selects the bit. After bit 7, goes to STOP_BIT.
- STOP_BIT: holds uart_tx=1 for CLKS_PER_BIT cycles, then:
  - byte index < 5: increment index and go to START_BIT. No idle gap between bytes.
  - byte index = 5: go to IDLE, busy=0, done=1 for one cycle, byte index=0.
- Frame length: 6*10*CLKS_PER_BIT cycles (12480 at defaults). done is visible after edge E0+12480.
- Baud counter: counts 0..CLKS_PER_BIT-1, clears on each bit boundary, and is held at 0 in IDLE. Its width is sized by $clog2(CLKS_PER_BIT).
- Busy rules:
  - start while busy=1 is ignored. dropped pulses one cycle. The frame in flight and its buffered data are unaffected.
  - In the done cycle busy=0, so a start on that edge is accepted. The next frame's start bit begins one cycle after the done-cycle edge, giving exactly one extra idle-high cycle.
  - start held high continuously produces back-to-back frames, each separated by that one idle cycle. It does not produce dropped pulses while waiting in IDLE.
- data_in changes after acceptance have no effect on the frame in progress.
- Reset mid-frame: the frame is aborted immediately, uart_tx returns high asynchronously, and all outputs take their reset values. No done is issued. The far-end receiver sees a truncated frame and must resynchronise on SYNC_BYTE.
- start and reset together: reset wins and nothing is accepted.
- done and dropped are never asserted in the same cycle.

Decomposition:
- Shared package fp_link_pkg:
  - SYNC_BYTE default and FRAME_BYTES=6.
  - FSM state encoding (2-bit localparams).
  - Checksum function fp_chk(word32) returning XOR of its bytes. The receive-side checker must use the same function.
- Sub-module uart_tx_byte:
  - Ports: clk, rst_n, tx_valid, tx_data[7:0], tx_ready, tx_line.
  - Contains the baud counter and the START/DATA/STOP sequencing.
  - The top level holds the frame buffer, byte index, checksum, and the busy/done/dropped logic.

Test Plan:
- data_in=32'h0019_8000, start pulse: the line decodes to A5 00 19 80 00 99. Each start bit is low exactly 208 cycles. done is one cycle at E0+12480, and busy=0 in that same cycle.
- data_in=32'hFFFF_FFFF: frame is A5 FF FF FF FF 00. Checksum zero. Stop bits are high 208 cycles each with no inter-byte gap.
- start pulsed at cycle 5000 of a frame with data 32'h1234_5678: dropped=1 for one cycle, and the in-flight frame bytes are unchanged.
- rst_n=1 during byte 3, bit 4: uart_tx=1 in the same cycle, busy=0, no done. After reset release, start with 32'hDEAD_BEEF yields the complete frame A5 DE AD BE EF 22.
- start held high for two frames: two complete frames separated by exactly one idle-high cycle, two done pulses, zero dropped pulses.
- BAUD_RATE=115_200 override: CLKS_PER_BIT=104, and the frame completes in 6240 cycles with correct bytes.
